// File: rtl/dq_timing_pkg.sv
// Shared DDR CAS timing types and helpers for the CAS spacing tracker.
// Holds the CAS type encoding, the counter sizing function and parameter checks.
package dq_timing_pkg;

    typedef enum logic {
        CAS_RD = 1'b0,
        CAS_WR = 1'b1
    } cas_type_e;

    function automatic int max_spacing(
        input int ccds,
        input int ccdl,
        input int wrrds,
        input int wrrdl,
        input int rdwr
    );
        int m;
        m = ccds;
        if (ccdl  > m) m = ccdl;
        if (wrrds > m) m = wrrds;
        if (wrrdl > m) m = wrrdl;
        if (rdwr  > m) m = rdwr;
        return m;
    endfunction

    // Width of a counter that must hold values up to max_s - 1.
    function automatic int gap_width(input int max_s);
        int w;
        w = $clog2(max_s);
        if (w < 1) w = 1;
        return w;
    endfunction

    function automatic bit spacings_legal(
        input int ccds,
        input int ccdl,
        input int wrrds,
        input int wrrdl,
        input int rdwr
    );
        bit ok;
        ok = 1'b1;
        if (ccds < 1 || ccdl < 1 || wrrds < 1 || wrrdl < 1 || rdwr < 1) ok = 1'b0;
        if (ccdl < ccds)   ok = 1'b0;
        if (wrrdl < wrrds) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/cas_gap_counter.sv
// Saturating down-counter for one CAS spacing window.
// A load never shortens a pending window: the larger of the decremented count and loadVal wins.
module cas_gap_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_dec;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_dec  = (count_q == '0) ? '0 : count_q - WIDTH'(1);
        count_next = count_dec;
        if (load && (loadVal > count_dec)) begin
            count_next = loadVal;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_next;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/dq_cas_spacing_tracker.sv
// Per-bank-group RD/WR CAS availability for one DDR channel, plus a sticky
// flag that records any CAS issued into a closed window.
module dq_cas_spacing_tracker
    import dq_timing_pkg::*;
#(
    parameter int NUM_BG = 4,
    parameter int tCCDS  = 4,
    parameter int tCCDL  = 6,
    parameter int tWRRDS = 10,
    parameter int tWRRDL = 14,
    parameter int tRDWR  = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    casAck,
    input  logic                                    casIsWr,
    input  logic [((NUM_BG > 1) ? $clog2(NUM_BG) : 1)-1:0] casBg,
    output logic [NUM_BG-1:0]                       rdAvail,
    output logic [NUM_BG-1:0]                       wrAvail,
    output logic                                    spacingViol
);

    localparam int BG_W    = (NUM_BG > 1) ? $clog2(NUM_BG) : 1;
    localparam int BG_SPAN = 2 ** BG_W;
    localparam int MAX_S   = max_spacing(tCCDS, tCCDL, tWRRDS, tWRRDL, tRDWR);
    localparam int CNT_W   = gap_width(MAX_S);

    localparam logic [CNT_W-1:0] LD_CCDS  = CNT_W'(tCCDS - 1);
    localparam logic [CNT_W-1:0] LD_CCDL  = CNT_W'(tCCDL - 1);
    localparam logic [CNT_W-1:0] LD_WRRDS = CNT_W'(tWRRDS - 1);
    localparam logic [CNT_W-1:0] LD_WRRDL = CNT_W'(tWRRDL - 1);
    localparam logic [CNT_W-1:0] LD_RDWR  = CNT_W'(tRDWR - 1);

    if (!spacings_legal(tCCDS, tCCDL, tWRRDS, tWRRDL, tRDWR)) begin : g_bad_timing
        $error("dq_cas_spacing_tracker: illegal CAS spacing parameters");
    end
    if (NUM_BG < 1) begin : g_bad_bg
        $error("dq_cas_spacing_tracker: NUM_BG must be at least 1");
    end

    cas_type_e          cas_type;
    logic [BG_SPAN-1:0] bg_ok_mask;
    logic [BG_SPAN-1:0] rd_avail_ext;
    logic [BG_SPAN-1:0] wr_avail_ext;
    logic               bg_valid;
    logic               sel_avail;
    logic               cas_load;
    logic               viol_next;

    always_comb begin
        bg_ok_mask = '0;
        for (int i = 0; i < BG_SPAN; i++) begin
            bg_ok_mask[i] = (i < NUM_BG);
        end
    end

    assign cas_type = cas_type_e'(casIsWr);
    assign bg_valid = bg_ok_mask[casBg];
    // An out-of-range bank group must not disturb any window.
    assign cas_load = casAck && bg_valid;

    for (genvar g = 0; g < NUM_BG; g++) begin : g_bg
        logic             same_bg;
        logic [CNT_W-1:0] rd_load_val;
        logic [CNT_W-1:0] wr_load_val;

        assign same_bg = (casBg == BG_W'(g));

        always_comb begin
            rd_load_val = same_bg ? LD_CCDL : LD_CCDS;
            wr_load_val = LD_RDWR;
            if (cas_type == CAS_WR) begin
                rd_load_val = same_bg ? LD_WRRDL : LD_WRRDS;
                wr_load_val = same_bg ? LD_CCDL : LD_CCDS;
            end
        end

        cas_gap_counter #(
            .WIDTH (CNT_W)
        ) u_rd_cnt (
            .clk     (clk),
            .rst     (rst),
            .load    (cas_load),
            .loadVal (rd_load_val),
            .zero    (rdAvail[g])
        );

        cas_gap_counter #(
            .WIDTH (CNT_W)
        ) u_wr_cnt (
            .clk     (clk),
            .rst     (rst),
            .load    (cas_load),
            .loadVal (wr_load_val),
            .zero    (wrAvail[g])
        );
    end

    assign rd_avail_ext = BG_SPAN'(rdAvail);
    assign wr_avail_ext = BG_SPAN'(wrAvail);

    always_comb begin
        sel_avail = (cas_type == CAS_WR) ? wr_avail_ext[casBg] : rd_avail_ext[casBg];
        viol_next = spacingViol;
        if (casAck && (!bg_valid || !sel_avail)) begin
            viol_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            spacingViol <= 1'b0;
        end else begin
            spacingViol <= viol_next;
        end
    end

endmodule

// File: tb/tb_dq_cas_spacing_tracker.sv
// Directed bench for dq_cas_spacing_tracker with default timing parameters.
// Outputs are sampled 1ns after the rising edge; j counts edges after the issue edge.
module tb_dq_cas_spacing_tracker;

    logic       clk;
    logic       rst;
    logic       casAck;
    logic       casIsWr;
    logic [1:0] casBg;
    logic [3:0] rdAvail;
    logic [3:0] wrAvail;
    logic       spacingViol;

    int compared;
    int mismatched;

    dq_cas_spacing_tracker dut (
        .clk         (clk),
        .rst         (rst),
        .casAck      (casAck),
        .casIsWr     (casIsWr),
        .casBg       (casBg),
        .rdAvail     (rdAvail),
        .wrAvail     (wrAvail),
        .spacingViol (spacingViol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [1:0] bg);
        casAck  = 1'b1;
        casIsWr = wr;
        casBg   = bg;
        @(posedge clk);
        #1;
        casAck  = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst     = 1'b0;
        casAck  = 1'b0;
        casIsWr = 1'b0;
        casBg   = 2'd0;
        idle(2);
        check_vec("reset_rd", rdAvail, 4'b1111);
        check_vec("reset_wr", wrAvail, 4'b1111);
        check_bit("reset_viol", spacingViol, 1'b0);
        rst = 1'b1;
        idle(5);
        check_vec("idle_rd", rdAvail, 4'b1111);
        check_vec("idle_wr", wrAvail, 4'b1111);
        check_bit("idle_viol", spacingViol, 1'b0);

        // RD to bank group 0
        issue(1'b0, 2'd0);
        check_vec("rd0_j0_rd", rdAvail, 4'b0000);
        check_vec("rd0_j0_wr", wrAvail, 4'b0000);
        idle(2);
        check_vec("rd0_j2_rd", rdAvail, 4'b0000);
        idle(1);
        check_vec("rd0_j3_rd", rdAvail, 4'b1110);
        idle(1);
        check_vec("rd0_j4_rd", rdAvail, 4'b1110);
        idle(1);
        check_vec("rd0_j5_rd", rdAvail, 4'b1111);
        check_vec("rd0_j5_wr", wrAvail, 4'b0000);
        idle(1);
        check_vec("rd0_j6_wr", wrAvail, 4'b0000);
        idle(1);
        check_vec("rd0_j7_wr", wrAvail, 4'b1111);
        check_bit("rd0_viol", spacingViol, 1'b0);

        // WR to bank group 2
        issue(1'b1, 2'd2);
        check_vec("wr2_j0_rd", rdAvail, 4'b0000);
        check_vec("wr2_j0_wr", wrAvail, 4'b0000);
        idle(2);
        check_vec("wr2_j2_wr", wrAvail, 4'b0000);
        idle(1);
        check_vec("wr2_j3_wr", wrAvail, 4'b1011);
        idle(1);
        check_vec("wr2_j4_wr", wrAvail, 4'b1011);
        idle(1);
        check_vec("wr2_j5_wr", wrAvail, 4'b1111);
        idle(3);
        check_vec("wr2_j8_rd", rdAvail, 4'b0000);
        idle(1);
        check_vec("wr2_j9_rd", rdAvail, 4'b1011);
        idle(3);
        check_vec("wr2_j12_rd", rdAvail, 4'b1011);
        idle(1);
        check_vec("wr2_j13_rd", rdAvail, 4'b1111);
        check_bit("wr2_viol", spacingViol, 1'b0);

        // RD bg1, then legal RD bg1 exactly tCCDL later
        issue(1'b0, 2'd1);
        idle(4);
        check_vec("rr1_a_j4_rd", rdAvail, 4'b1101);
        idle(1);
        check_vec("rr1_a_j5_rd", rdAvail, 4'b1111);
        issue(1'b0, 2'd1);
        check_bit("rr1_b_viol", spacingViol, 1'b0);
        check_vec("rr1_b_j0_rd", rdAvail, 4'b0000);
        idle(4);
        check_vec("rr1_b_j4_rd", rdAvail, 4'b1101);
        idle(1);
        check_vec("rr1_b_j5_rd", rdAvail, 4'b1111);
        check_vec("rr1_b_j5_wr", wrAvail, 4'b0000);
        idle(2);
        check_vec("rr1_b_j7_wr", wrAvail, 4'b1111);
        check_bit("rr1_viol_end", spacingViol, 1'b0);

        // WR bg0, illegal RD bg0 three edges later; longer WR->RD window survives
        issue(1'b1, 2'd0);
        idle(2);
        check_bit("wr_rd_pre_viol", spacingViol, 1'b0);
        issue(1'b0, 2'd0);
        check_bit("wr_rd_viol", spacingViol, 1'b1);
        check_vec("wr_rd_j0_rd", rdAvail, 4'b0000);
        idle(6);
        check_vec("wr_rd_j6_rd", rdAvail, 4'b1110);
        check_vec("wr_rd_j6_wr", wrAvail, 4'b0000);
        idle(1);
        check_vec("wr_rd_j7_wr", wrAvail, 4'b1111);
        check_vec("wr_rd_j7_rd", rdAvail, 4'b1110);
        idle(3);
        check_vec("wr_rd_j10_rd", rdAvail, 4'b1111);
        check_bit("wr_rd_viol_held", spacingViol, 1'b1);

        // Reset mid-window with casAck held during reset
        issue(1'b1, 2'd3);
        idle(1);
        rst     = 1'b0;
        casAck  = 1'b1;
        casIsWr = 1'b0;
        casBg   = 2'd3;
        idle(1);
        check_vec("rst_mid_rd", rdAvail, 4'b1111);
        check_vec("rst_mid_wr", wrAvail, 4'b1111);
        check_bit("rst_mid_viol", spacingViol, 1'b0);
        idle(1);
        check_vec("rst_hold_rd", rdAvail, 4'b1111);
        check_bit("rst_hold_viol", spacingViol, 1'b0);
        rst    = 1'b1;
        casAck = 1'b0;
        idle(1);
        check_vec("rst_rel_rd", rdAvail, 4'b1111);
        check_vec("rst_rel_wr", wrAvail, 4'b1111);
        check_bit("rst_rel_viol", spacingViol, 1'b0);

        // RD->WR boundary: WR legal exactly tRDWR after the RD, then back-to-back WR illegal
        issue(1'b0, 2'd3);
        idle(6);
        check_vec("rdwr_j6_wr", wrAvail, 4'b0000);
        idle(1);
        check_vec("rdwr_j7_wr", wrAvail, 4'b1111);
        issue(1'b1, 2'd3);
        check_bit("rdwr_legal_viol", spacingViol, 1'b0);
        check_vec("rdwr_wr_j0_wr", wrAvail, 4'b0000);
        issue(1'b1, 2'd3);
        check_bit("wrwr_early_viol", spacingViol, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
